// File: rtl/sum_display_driver.sv
// sum_display_driver: captures a 12-bit binary sum on a load strobe, converts it
// to four BCD digits with a sequential double-dabble (one shift per clock), and
// scans the last completed result onto a 4-digit common-anode 7-segment display
// with optional leading-zero blanking.
module sum_display_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] sum,
   input  logic        load,
   output logic        busy,
   output logic [15:0] bcd,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t         state_q;
   logic [11:0]    bin_q;
   logic [15:0]    acc_q;
   logic [3:0]     cnt_q;
   logic           busy_q;
   logic [15:0]    bcd_q;

   logic [RW-1:0]  refresh_q, refresh_d;
   logic [1:0]     idx_q, idx_d;
   logic [3:0]     an_q, an_d;
   logic [6:0]     seg_q, seg_d;

   logic [15:0]    acc_adj;
   logic [15:0]    acc_d;

   // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
   function automatic logic [15:0] add3_digits(input logic [15:0] a);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ? a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
      end
      return r;
   endfunction

   // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes are blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // True when digit idx and every digit above it are zero (units never qualify).
   function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] idx);
      case (idx)
         2'd1:    return (v[15:4] == 12'd0);
         2'd2:    return (v[15:8] == 8'd0);
         2'd3:    return (v[15:12] == 4'd0);
         default: return 1'b0;
      endcase
   endfunction

   // Next accumulator value: adjust digits, then shift in the next binary bit.
   always_comb begin
      acc_adj = add3_digits(acc_q);
      acc_d   = {acc_adj[14:0], bin_q[11]};
   end

   // Conversion FSM: IDLE waits for load, CONV performs twelve adjust-and-shift steps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bin_q   <= 12'd0;
         acc_q   <= 16'd0;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         bcd_q   <= 16'h0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  bin_q   <= sum;
                  acc_q   <= 16'd0;
                  cnt_q   <= 4'd12;
                  busy_q  <= 1'b1;
                  state_q <= CONV;
               end
            end
            CONV: begin
               acc_q <= acc_d;
               bin_q <= {bin_q[10:0], 1'b0};
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  bcd_q   <= acc_d;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Scan timing and the digit/segment values to register this edge.
   always_comb begin
      if (refresh_q == REFRESH_LAST) begin
         refresh_d = '0;
         idx_d     = idx_q + 2'd1;
      end else begin
         refresh_d = refresh_q + RW'(1);
         idx_d     = idx_q;
      end
      an_d = ~(4'b0001 << idx_d);
      if ((BLANK_LZ != 0) && leading_zero(bcd_q, idx_d)) begin
         seg_d = 7'b1111111;
      end else begin
         seg_d = seg_decode(bcd_q[idx_d*4 +: 4]);
      end
   end

   // Display scan registers: anode and segments update together every edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_q <= '0;
         idx_q     <= 2'd0;
         an_q      <= 4'b1110;
         seg_q     <= 7'b1000000;
      end else begin
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign busy = busy_q;
   assign bcd  = bcd_q;
   assign an   = an_q;
   assign seg  = seg_q;

endmodule
